// File: rtl/fsm_stim_driver.sv
// Stimulus driver for a small clocked FSM under test: plays an LFSR stream
// or a cyclic directed pattern on `a`, watches the FSM state for a target,
// counts cycles and hits, and stops on hit or timeout.
//
// Ports:
//   clock, reset_n       rising-edge clock, async active-low reset
//   start                one-cycle pulse, starts a run from IDLE or DONE
//   reseed, stop_on_hit  sampled with start
//   mode                 0 = LFSR stream, 1 = directed pattern
//   pattern              directed bits, played LSB first, cyclic
//   state                current state of the FSM under test
//   a                    registered drive bit to the FSM
//   busy, done           run in progress / run finished
//   hit, timeout         sticky result flags of the last run
//   cycles, hits         saturating run-cycle and target-hit counters
//   history              last PAT_W driven bits, newest in bit 0
module fsm_stim_driver #(
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
    parameter int                ST_W       = 2,
    parameter logic [ST_W-1:0]   TARGET     = 2'b10,
    parameter int                MAX_CYCLES = 20,
    parameter int                PAT_W      = 8,
    parameter int                CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             reseed,
    input  logic             mode,
    input  logic             stop_on_hit,
    input  logic [PAT_W-1:0] pattern,
    input  logic [ST_W-1:0]  state,
    output logic             a,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] hits,
    output logic [PAT_W-1:0] history
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } st_t;

    st_t               fsm;
    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W-1:0]  idx;
    logic              soh;

    logic d;
    logic hit_now;
    logic last_cycle;

    assign d          = mode ? pattern[idx] : lfsr[0];
    assign hit_now    = (state == TARGET);
    assign last_cycle = (cycles == CNT_W'(MAX_CYCLES - 1));

    assign busy = (fsm == RUN);
    assign done = (fsm == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm     <= IDLE;
            lfsr    <= SEED;
            idx     <= '0;
            soh     <= 1'b0;
            a       <= 1'b0;
            hit     <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
            hits    <= '0;
            history <= '0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (start) begin
                        // `a` keeps its value on the start edge
                        fsm     <= RUN;
                        cycles  <= '0;
                        hits    <= '0;
                        hit     <= 1'b0;
                        timeout <= 1'b0;
                        history <= '0;
                        idx     <= '0;
                        soh     <= stop_on_hit;
                        if (reseed) lfsr <= SEED;
                    end else begin
                        a <= 1'b0;
                    end
                end
                RUN: begin
                    a       <= d;
                    history <= {history[PAT_W-2:0], d};
                    idx     <= (idx == IDX_W'(PAT_W - 1)) ? '0 : idx + 1'b1;
                    if (!mode)
                        lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
                    if (!(&cycles)) cycles <= cycles + 1'b1;
                    if (hit_now) begin
                        hit <= 1'b1;
                        if (!(&hits)) hits <= hits + 1'b1;
                    end
                    // a stopping hit takes priority over the timeout
                    if (soh && hit_now) begin
                        fsm <= DONE;
                    end else if (last_cycle) begin
                        fsm     <= DONE;
                        timeout <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Directed self-checking bench for fsm_stim_driver.
// Each task drives one scenario and checks results inline.
module tb_fsm_stim_driver;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       reseed = 1'b0;
    logic       mode = 1'b0;
    logic       stop_on_hit = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [1:0] state = 2'b00;
    logic       a;
    logic       busy;
    logic       done;
    logic       hit;
    logic       timeout;
    logic [7:0] cycles;
    logic [7:0] hits;
    logic [7:0] history;

    int n_checks = 0;
    int n_fail = 0;

    fsm_stim_driver dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .reseed      (reseed),
        .mode        (mode),
        .stop_on_hit (stop_on_hit),
        .pattern     (pattern),
        .state       (state),
        .a           (a),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .timeout     (timeout),
        .cycles      (cycles),
        .hits        (hits),
        .history     (history)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic rs, input logic md, input logic sh);
        start       = 1'b1;
        reseed      = rs;
        mode        = md;
        stop_on_hit = sh;
        tick();
        start  = 1'b0;
        reseed = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({a, busy, done, hit, timeout, cycles, hits, history} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 0",
                     {a, busy, done, hit, timeout, cycles, hits, history});
        end
        tick();
        n_checks++;
        if ({busy, cycles} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_held: busy=%b cycles=%0d want 0", busy, cycles);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        do_start(1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        n_checks++;
        if (busy !== 1'b1 || cycles !== 8'd5 || history !== 8'h10) begin
            n_fail++;
            $display("FAIL midrun_pre: busy=%b cycles=%0d hist=%h want 1 5 10",
                     busy, cycles, history);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a, busy, cycles, hits, history} !== 26'd0) begin
            n_fail++;
            $display("FAIL midrun_abort: a=%b busy=%b cycles=%0d hits=%0d hist=%h want 0",
                     a, busy, cycles, hits, history);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_lfsr();
        logic [5:0] exp_a;
        exp_a = 6'b100001;
        state = 2'b00;
        do_start(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (a !== exp_a[5-i]) begin
                n_fail++;
                $display("FAIL lfsr_bit%0d: a=%b want %b", i, a, exp_a[5-i]);
            end
        end
        repeat (13) tick();
        n_checks++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL lfsr_edge19: busy=%b timeout=%b want 1 0", busy, timeout);
        end
        tick();
        n_checks++;
        if (timeout !== 1'b1 || cycles !== 8'd20) begin
            n_fail++;
            $display("FAIL lfsr_timeout: timeout=%b cycles=%0d want 1 20", timeout, cycles);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || hit !== 1'b0 || hits !== 8'd0) begin
            n_fail++;
            $display("FAIL lfsr_end: busy=%b done=%b hit=%b hits=%0d want 0 1 0 0",
                     busy, done, hit, hits);
        end
        tick();
        n_checks++;
        if (a !== 1'b0 || cycles !== 8'd20 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL lfsr_done_hold: a=%b cycles=%0d done=%b want 0 20 1",
                     a, cycles, done);
        end
    endtask

    task automatic test_pattern();
        logic [9:0] exp_a;
        exp_a   = 10'b0110010101;
        pattern = 8'b1010_0110;
        state   = 2'b00;
        do_start(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (a !== exp_a[9-i]) begin
                n_fail++;
                $display("FAIL pat_bit%0d: a=%b want %b", i, a, exp_a[9-i]);
            end
            if (i == 7) begin
                n_checks++;
                if (history !== 8'b0110_0101) begin
                    n_fail++;
                    $display("FAIL pat_history: got %b want 01100101", history);
                end
            end
        end
        repeat (10) tick();
        n_checks++;
        if (done !== 1'b1 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL pat_end: done=%b timeout=%b want 1 1", done, timeout);
        end
    endtask

    task automatic test_stop_on_hit();
        do_start(1'b0, 1'b1, 1'b1);
        state = 2'b11;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b1 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL soh_pre: busy=%b hit=%b want 1 0", busy, hit);
        end
        state = 2'b10;
        tick();
        state = 2'b00;
        n_checks++;
        if (done !== 1'b1 || hit !== 1'b1 || hits !== 8'd1 ||
            cycles !== 8'd4 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL soh_stop: done=%b hit=%b hits=%0d cycles=%0d to=%b want 1 1 1 4 0",
                     done, hit, hits, cycles, timeout);
        end
    endtask

    task automatic test_hit_count();
        logic [15:0] mdl;
        do_start(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            state = (i % 2 == 0) ? 2'b10 : 2'b01;
            tick();
        end
        state = 2'b00;
        n_checks++;
        if (hits !== 8'd10 || hit !== 1'b1 || timeout !== 1'b1 || cycles !== 8'd20) begin
            n_fail++;
            $display("FAIL hitcnt_end: hits=%0d hit=%b to=%b cycles=%0d want 10 1 1 20",
                     hits, hit, timeout, cycles);
        end
        tick();
        mdl = 16'hACE1;
        repeat (20) mdl = lfsr_step(mdl);
        do_start(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({cycles, hits, hit, timeout, history} !== 26'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: cyc=%0d hits=%0d hit=%b to=%b hist=%h busy=%b",
                     cycles, hits, hit, timeout, history, busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (a !== mdl[0]) begin
                n_fail++;
                $display("FAIL lfsr_cont%0d: a=%b want %b", i, a, mdl[0]);
            end
            mdl = lfsr_step(mdl);
        end
        repeat (12) tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_end: done=%b want 1", done);
        end
    endtask

    task automatic test_simul_hit_timeout();
        state = 2'b00;
        do_start(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            state = (i == 20) ? 2'b10 : 2'b00;
            start = (i == 5);
            tick();
            start = 1'b0;
            if (i == 5) begin
                n_checks++;
                if (busy !== 1'b1 || cycles !== 8'd5) begin
                    n_fail++;
                    $display("FAIL start_in_run: busy=%b cycles=%0d want 1 5", busy, cycles);
                end
            end
        end
        state = 2'b00;
        n_checks++;
        if (hit !== 1'b1 || timeout !== 1'b0 || cycles !== 8'd20 ||
            hits !== 8'd1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL simul: hit=%b to=%b cycles=%0d hits=%0d done=%b want 1 0 20 1 1",
                     hit, timeout, cycles, hits, done);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_lfsr();
        test_pattern();
        test_stop_on_hit();
        test_hit_count();
        test_simul_hit_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_stim_driver.md
Name: fsm_stim_driver

Overview:
- Drives the single-bit input `a` of a small clocked FSM under test, either as a pseudo-random LFSR stream or as a repeating directed pattern.
- Monitors the FSM's state bits, detects the target state, counts cycles and hits, and stops on hit or on timeout.
- Sits beside the FSM on the same clock and replaces `$random` stimulus with reproducible, synthesizable stimulus.

Parameters:
- LFSR_W, 16, LFSR width.
- SEED, 16'hACE1, LFSR load value at reset and on reseed.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- ST_W, 2, width of observed FSM state.
- TARGET, 2'b10, state value that counts as a hit.
- MAX_CYCLES, 20, RUN cycles before timeout (>=1).
- PAT_W, 8, directed pattern length.
- CNT_W, 8, width of cycle and hit counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts a run from IDLE or DONE.
- reseed  in  1  sampled with start; 1 reloads LFSR with SEED.
- mode  in  1  0 = LFSR stream, 1 = directed pattern.
- stop_on_hit  in  1  sampled with start; 1 ends the run at the first hit.
- pattern  in  PAT_W  directed bits, played LSB first, repeating cyclically.
- state  in  ST_W  current state of the FSM under test.
- a  out  1  registered drive bit to the FSM.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- hit  out  1  sticky; the target was seen during the last run.
- timeout  out  1  sticky; the last run ended by MAX_CYCLES.
- cycles  out  CNT_W  RUN cycles elapsed in the current or last run.
- hits  out  CNT_W  target occurrences, saturating at all-ones.
- history  out  PAT_W  last PAT_W values of `a`, newest in bit 0.

Behaviour:
- Reset (reset_n=0, async):
  - FSM enters IDLE.
  - a=0, busy=0, done=0, hit=0, timeout=0, cycles=0, hits=0, history=0.
  - LFSR=SEED, pattern index=0.
  - Reset asserted mid-run aborts immediately; no partial results are held.
- States: IDLE, RUN, DONE. Outputs: busy = (state==RUN), done = (state==DONE).
- IDLE/DONE with start=1, next edge:
  - go to RUN; clear cycles, hits, hit, timeout, history; pattern index=0.
  - latch stop_on_hit.
  - if reseed=1, LFSR=SEED; otherwise the LFSR continues from its current value.
  - `a` is held at its previous value on the start edge.
- RUN, every edge:
  - Drive bit d = mode ? pattern[idx] : lfsr[0].
  - a<=d; history<={history[PAT_W-2:0],d}; idx<=(idx==PAT_W-1)?0:idx+1.
  - LFSR steps only when mode=0: lfsr<=(lfsr>>1)^(lfsr[0]?TAPS:0).
  - cycles<=cycles+1, saturating.
- Hit detection in RUN:
  - the `state` input is sampled at the edge; state==TARGET means hits<=hits+1 (saturating) and hit<=1.
  - With stop_on_hit=1, a hit moves the FSM to DONE on that same edge.
- Timeout: in RUN, when cycles==MAX_CYCLES-1 at an edge, go to DONE and set timeout<=1.
  - If a hit also occurs on that edge, hit wins when stop_on_hit=1, and timeout stays 0.
  - With stop_on_hit=0, both hit and timeout may be 1.
- DONE: `a` returns to 0 at the next edge; all counters and flags hold until the next start.
- start while in RUN is ignored.
- Latency: first driven bit appears on `a` one edge after the start edge; the FSM sees it on the edge after that.
- `pattern` and `mode` may change during RUN; the change takes effect on the next edge.

Test Plan:
- Reset mid-run: start, run 5 cycles, pulse reset_n low between edges.
  - Required: a=0, busy=0, cycles=0, hits=0 immediately, without waiting for a clock edge.
- LFSR stream: reset, start with reseed=1, mode=0, state held at 2'b00.
  - Required: `a` over the first 6 RUN edges is 1,0,0,0,0,1.
  - Required: timeout=1 and cycles=20 at the 20th RUN edge; busy falls; hit=0; hits=0.
- Directed pattern: mode=1, pattern=8'b1010_0110, state held at 2'b00.
  - Required: `a` is 0,1,1,0,0,1,0,1, then repeats 0,1,...
  - Required: history=8'b0110_0101 after 8 edges.
- Stop on hit: stop_on_hit=1, state=2'b11 for 3 RUN edges, then 2'b10.
  - Required: DONE on that edge with hit=1, hits=1, cycles=4, timeout=0.
- Hit counting: stop_on_hit=0, state toggles 2'b10/2'b01 every edge.
  - Required: hits=10, hit=1, timeout=1, cycles=20 at the end.
  - Then start with reseed=0 in DONE. Required: counters clear and the LFSR continues without reloading.
- Simultaneous hit and timeout: stop_on_hit=1, MAX_CYCLES=20, state first equals 2'b10 on the 20th RUN edge.
  - Required: hit=1, timeout=0, cycles=20.
  - start pulsed during RUN: required to have no effect.
